// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use stall, taken-branch squash,
// data-memory wait freeze with timeout, debug halt/drain and saturating counters.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 16,
  parameter int TMR_W        = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic             ex_mem_flush,
  output logic             mem_wb_bubble,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [2:0] {S_RUN, S_MEM_WAIT, S_DRAIN, S_HALTED, S_ERROR} state_t;

  state_t             r_state, w_state_next;
  logic [TMR_W-1:0]   r_timer, w_timer_next;
  logic [TMR_W-1:0]   r_drain, w_drain_next;
  logic               r_halted;
  logic               r_mem_timeout;
  logic               w_lu;
  logic               w_wait;
  logic [1:0]         w_cnt_inc;
  logic [2*CNT_W-1:0] w_cnt_flat;

  assign w_lu   = ex_mem_read & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  assign w_wait = dmem_req & ~dmem_ready;

  always_comb begin
    pc_write      = 1'b1;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_hold    = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_hold   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    w_state_next  = r_state;
    w_timer_next  = r_timer;
    w_drain_next  = r_drain;
    w_cnt_inc     = 2'b00;

    if (rst) begin
      pc_write      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_flush  = 1'b1;
      mem_wb_bubble = 1'b1;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_wait) begin
            pc_write      = 1'b0;
            if_id_hold    = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_hold   = 1'b1;
            mem_wb_bubble = 1'b1;
            w_timer_next  = TMR_W'(1);
            w_state_next  = S_MEM_WAIT;
          end else if (mem_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            w_cnt_inc[1] = 1'b1;
            if (halt_req) begin
              w_drain_next = '0;
              w_state_next = S_DRAIN;
            end
          end else if (w_lu) begin
            // Halt entry waits until the load-use stall has resolved.
            pc_write     = 1'b0;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (halt_req) begin
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
            w_drain_next = TMR_W'(1);
            w_state_next = S_DRAIN;
          end
        end

        S_MEM_WAIT: begin
          if (!dmem_ready) begin
            pc_write      = 1'b0;
            if_id_hold    = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_hold   = 1'b1;
            mem_wb_bubble = 1'b1;
            if (r_timer == TMR_W'(TIMEOUT)) begin
              w_state_next = S_ERROR;
            end else begin
              w_timer_next = r_timer + TMR_W'(1);
            end
          end else begin
            w_timer_next = '0;
            w_state_next = S_RUN;
          end
        end

        S_DRAIN: begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          if (w_wait) begin
            // Frozen drain cycles do not count and never time out.
            if_id_hold    = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_hold   = 1'b1;
            mem_wb_bubble = 1'b1;
          end else begin
            if (mem_branch_taken) begin
              pc_write     = 1'b1;
              id_ex_bubble = 1'b1;
              ex_mem_flush = 1'b1;
              w_cnt_inc[1] = 1'b1;
            end
            w_drain_next = r_drain + TMR_W'(1);
            if (w_drain_next == TMR_W'(DRAIN_CYCLES)) begin
              w_state_next = S_HALTED;
            end
          end
        end

        S_HALTED: begin
          pc_write      = 1'b0;
          if_id_flush   = 1'b1;
          id_ex_bubble  = 1'b1;
          ex_mem_flush  = 1'b1;
          mem_wb_bubble = 1'b1;
          if (!halt_req) begin
            w_state_next = S_RUN;
          end
        end

        S_ERROR: begin
          pc_write      = 1'b0;
          if_id_hold    = 1'b1;
          id_ex_hold    = 1'b1;
          ex_mem_hold   = 1'b1;
          mem_wb_bubble = 1'b1;
        end

        default: begin
          w_state_next = S_RUN;
        end
      endcase
    end

    w_cnt_inc[0] = ~rst & ~pc_write & ((r_state == S_RUN) | (r_state == S_MEM_WAIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_timer       <= '0;
      r_drain       <= '0;
      r_halted      <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_timer       <= w_timer_next;
      r_drain       <= w_drain_next;
      r_halted      <= (w_state_next == S_HALTED);
      r_mem_timeout <= r_mem_timeout | (w_state_next == S_ERROR);
    end
  end

  // Index 0 counts stall cycles, index 1 counts branch flushes.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_cnt_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      assign w_cnt_flat[gi*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate

  assign stall_cycles = w_cnt_flat[CNT_W-1:0];
  assign flush_events = w_cnt_flat[2*CNT_W-1:CNT_W];
  assign halted       = r_halted;
  assign mem_timeout  = r_mem_timeout;

endmodule
